instr_fetch_unit: RTL and testbench

Front-end fetch stage for the 4-byte-instruction CPU core. It reads instruction bytes from the byte-wide program RAM port and assembles them into {opcode, reg, operand lo, operand hi}. Assembled instructions are buffered in a small queue and handed to the downstream execute stage over a valid/ready handshake. The execute stage sends redirects (jumps) back to this block, which flushes the queue and restarts fetch.

---
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads program bytes, builds 4-byte instructions and queues them
// for the execute stage. Redirects flush the queue and restart fetch.
module instr_fetch_unit #(
  parameter int RAMSIZE = 64,
  parameter int AW      = 8,
  parameter int DEPTH   = 2
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [7:0]    instr_opcode,
  output logic [7:0]    instr_reg,
  output logic [15:0]   instr_operand,
  output logic [AW-1:0] instr_pc,
  output logic [AW-1:0] fetch_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1) + 1;
  localparam logic [AW-1:0] AMASK     = AW'(RAMSIZE - 1);
  localparam logic [OW-1:0] DEPTH_C   = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [7:0]    b3;
    logic [7:0]    b2;
    logic [7:0]    b1;
    logic [7:0]    b0;
  } entry_t;

  entry_t        q_mem [DEPTH];
  logic [AW-1:0] fpc_q, fpc_d;
  logic          busy_q, busy_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          in_asm_q, in_asm_d;
  logic          rd_pend_q, rd_pend_d;
  logic [1:0]    rd_idx_q, rd_idx_d;
  logic [23:0]   asm_q, asm_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;

  logic          cap_last, issue, pop, push;
  logic [1:0]    issue_idx;
  logic [AW-1:0] base;
  entry_t        head_e, push_e;

  always_comb begin
    cap_last  = rd_pend_q && (rd_idx_q == 2'd3);
    issue     = !redirect_valid && (busy_q || ((occ_q + OW'(in_asm_q)) < DEPTH_C));
    issue_idx = busy_q ? cnt_q : 2'd0;
    // A byte 0 issued alongside the byte-3 capture belongs to the next PC.
    base      = cap_last ? (fpc_q + AW'(4)) : fpc_q;
    pop       = (occ_q != '0) && instr_ready;
    push      = cap_last && !redirect_valid;
  end

  assign push_e   = '{pc: fpc_q, b3: mem_rdata, b2: asm_q[23:16], b1: asm_q[15:8], b0: asm_q[7:0]};
  assign mem_rd   = issue && !reset;
  assign mem_addr = reset ? '0 : ((base + AW'(issue_idx)) & AMASK);

  assign head_e        = q_mem[head_q];
  assign instr_valid   = (occ_q != '0);
  assign instr_opcode  = head_e.b0;
  assign instr_reg     = head_e.b1;
  assign instr_operand = {head_e.b3, head_e.b2};
  assign instr_pc      = head_e.pc;
  assign fetch_pc      = fpc_q;

  always_comb begin
    fpc_d     = fpc_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    in_asm_d  = in_asm_q;
    asm_d     = asm_q;
    head_d    = head_q;
    tail_d    = tail_q;
    rd_pend_d = issue;
    rd_idx_d  = issue_idx;
    occ_d     = occ_q + OW'(push) - OW'(pop);

    if (rd_pend_q) begin
      case (rd_idx_q)
        2'd0:    asm_d[7:0]   = mem_rdata;
        2'd1:    asm_d[15:8]  = mem_rdata;
        2'd2:    asm_d[23:16] = mem_rdata;
        default: ;
      endcase
    end
    if (cap_last) begin
      in_asm_d = 1'b0;
      fpc_d    = (fpc_q + AW'(4)) & AMASK;
    end
    if (issue) begin
      if (!busy_q) begin
        in_asm_d = 1'b1;
        busy_d   = 1'b1;
        cnt_d    = 2'd1;
      end else if (cnt_q == 2'd3) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
    if (push) tail_d = (tail_q == LAST_SLOT) ? '0 : tail_q + PW'(1);
    if (pop)  head_d = (head_q == LAST_SLOT) ? '0 : head_q + PW'(1);

    // Redirect wins over everything: flush queue and any partial instruction.
    if (redirect_valid) begin
      in_asm_d  = 1'b0;
      busy_d    = 1'b0;
      cnt_d     = 2'd0;
      rd_pend_d = 1'b0;
      rd_idx_d  = 2'd0;
      asm_d     = '0;
      occ_d     = '0;
      head_d    = '0;
      tail_d    = '0;
      fpc_d     = (redirect_addr & ~AW'(3)) & AMASK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q     <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= 2'd0;
      in_asm_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= 2'd0;
      asm_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
    end else begin
      fpc_q     <= fpc_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      in_asm_q  <= in_asm_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
      asm_q     <= asm_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_mem[gi] <= '0;
        end else if (push && (tail_q == PW'(gi))) begin
          q_mem[gi] <= push_e;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle-latency byte RAM model.
module tb_instr_fetch_unit;

  localparam int RAMSIZE = 64;
  localparam int AW      = 8;
  localparam int DEPTH   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_rdata = 8'h00;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [7:0]    instr_opcode, instr_reg;
  logic [15:0]   instr_operand;
  logic [AW-1:0] instr_pc, fetch_pc;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram [RAMSIZE];

  instr_fetch_unit #(.RAMSIZE(RAMSIZE), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_reg(instr_reg),
    .instr_operand(instr_operand), .instr_pc(instr_pc), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr[5:0]];
  end

  // Leaves the caller in cycle 0 (first cycle with reset low), inputs idle.
  task automatic restart();
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({mem_rd, mem_addr, instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc, fetch_pc} !== '0)
      $display("FAIL reset_outputs got rd=%0b addr=%h v=%0b op=%h rg=%h opd=%h pc=%h fpc=%h want all 0",
               mem_rd, mem_addr, instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc, fetch_pc);
    if ({mem_rd, mem_addr, instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc, fetch_pc} !== '0) bad++;
  endtask

  task automatic test_basic();
    logic [AW-1:0] exp_fpc;
    restart();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      instr_ready = 1'b1;
      #1;
      total++;
      if (mem_rd !== 1'b1 || mem_addr !== 8'(c)) begin
        bad++;
        $display("FAIL basic_fetch cyc=%0d got rd=%0b addr=%0d want rd=1 addr=%0d", c, mem_rd, mem_addr, c);
      end
      total++;
      if (instr_valid !== (c == 5 || c == 9)) begin
        bad++;
        $display("FAIL basic_valid cyc=%0d got %0b want %0b", c, instr_valid, (c == 5 || c == 9));
      end
      exp_fpc = (c == 0) ? 8'd0 : 8'(4 * ((c - 1) / 4));
      total++;
      if (fetch_pc !== exp_fpc) begin
        bad++;
        $display("FAIL basic_fetch_pc cyc=%0d got %h want %h", c, fetch_pc, exp_fpc);
      end
      if (c == 5) begin
        total++;
        if ({instr_opcode, instr_reg, instr_operand, instr_pc} !== {8'd2, 8'd0, 16'h0010, 8'd0}) begin
          bad++;
          $display("FAIL basic_instr0 got op=%h rg=%h opd=%h pc=%h want 02 00 0010 00",
                   instr_opcode, instr_reg, instr_operand, instr_pc);
        end
      end
      if (c == 9) begin
        total++;
        if ({instr_opcode, instr_reg, instr_operand, instr_pc} !== {8'd4, 8'd0, 16'h0001, 8'd4}) begin
          bad++;
          $display("FAIL basic_instr1 got op=%h rg=%h opd=%h pc=%h want 04 00 0001 04",
                   instr_opcode, instr_reg, instr_operand, instr_pc);
        end
      end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    restart();
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(negedge clk);
      instr_ready = (c >= 20);
      #1;
      total++;
      if (mem_rd !== (c < 8 || c == 21)) begin
        bad++;
        $display("FAIL stall_rd cyc=%0d got %0b want %0b", c, mem_rd, (c < 8 || c == 21));
      end
      total++;
      if (instr_valid !== (c >= 5)) begin
        bad++;
        $display("FAIL stall_valid cyc=%0d got %0b want %0b", c, instr_valid, (c >= 5));
      end
      if (c >= 5 && c <= 20) begin
        total++;
        if ({instr_opcode, instr_reg, instr_operand, instr_pc} !== {8'd2, 8'd0, 16'h0010, 8'd0}) begin
          bad++;
          $display("FAIL stall_head cyc=%0d got op=%h rg=%h opd=%h pc=%h want 02 00 0010 00",
                   c, instr_opcode, instr_reg, instr_operand, instr_pc);
        end
      end
      if (c == 21) begin
        total++;
        if ({instr_opcode, instr_reg, instr_operand, instr_pc, mem_addr} !== {8'd4, 8'd0, 16'h0001, 8'd4, 8'd8}) begin
          bad++;
          $display("FAIL stall_resume got op=%h rg=%h opd=%h pc=%h addr=%h want 04 00 0001 04 08",
                   instr_opcode, instr_reg, instr_operand, instr_pc, mem_addr);
        end
      end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect();
    restart();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      instr_ready = 1'b1;
      redirect_valid = (c == 6);
      redirect_addr = 8'h22;
      #1;
      if (c == 6) begin
        total++;
        if (mem_rd !== 1'b0) begin
          bad++;
          $display("FAIL redir_rd_off got %0b want 0", mem_rd);
        end
      end
      if (c >= 6) begin
        total++;
        if (instr_valid !== (c == 12)) begin
          bad++;
          $display("FAIL redir_valid cyc=%0d got %0b want %0b (pc=%h)", c, instr_valid, (c == 12), instr_pc);
        end
      end
      if (c == 7) begin
        total++;
        if ({mem_rd, mem_addr, fetch_pc} !== {1'b1, 8'h20, 8'h20}) begin
          bad++;
          $display("FAIL redir_restart got rd=%0b addr=%h fpc=%h want 1 20 20", mem_rd, mem_addr, fetch_pc);
        end
      end
      if (c == 12) begin
        total++;
        if ({instr_opcode, instr_reg, instr_operand, instr_pc} !== {8'h20, 8'h21, 16'h2322, 8'h20}) begin
          bad++;
          $display("FAIL redir_instr got op=%h rg=%h opd=%h pc=%h want 20 21 2322 20",
                   instr_opcode, instr_reg, instr_operand, instr_pc);
        end
      end
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] wa [6];
    wa = '{8'd60, 8'd61, 8'd62, 8'd63, 8'd0, 8'd1};
    restart();
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      instr_ready = 1'b1;
      redirect_valid = (c == 0);
      redirect_addr = 8'd60;
      #1;
      if (c == 0) begin
        total++;
        if (mem_rd !== 1'b0) begin
          bad++;
          $display("FAIL wrap_rd_off got %0b want 0", mem_rd);
        end
      end
      if (c >= 1 && c <= 6) begin
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== wa[c-1]) begin
          bad++;
          $display("FAIL wrap_addr cyc=%0d got rd=%0b addr=%0d want rd=1 addr=%0d", c, mem_rd, mem_addr, wa[c-1]);
        end
      end
      if (c == 6) begin
        total++;
        if ({instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc} !== {1'b1, 8'd60, 8'd61, 16'h3F3E, 8'd60}) begin
          bad++;
          $display("FAIL wrap_instr60 got v=%0b op=%h rg=%h opd=%h pc=%h want 1 3c 3d 3f3e 3c",
                   instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc);
        end
      end
      if (c == 10) begin
        total++;
        if ({instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc} !== {1'b1, 8'd2, 8'd0, 16'h0010, 8'd0}) begin
          bad++;
          $display("FAIL wrap_instr0 got v=%0b op=%h rg=%h opd=%h pc=%h want 1 02 00 0010 00",
                   instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc);
        end
      end
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_push();
    restart();
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      instr_ready = 1'b0;
      redirect_valid = (c == 4);
      redirect_addr = 8'h13;
      #1;
      if (c == 4) begin
        total++;
        if (mem_rd !== 1'b0) begin
          bad++;
          $display("FAIL rpush_rd_off got %0b want 0", mem_rd);
        end
      end
      if (c >= 5 && c <= 9) begin
        total++;
        if (instr_valid !== 1'b0) begin
          bad++;
          $display("FAIL rpush_dropped cyc=%0d got valid=%0b pc=%h want valid=0", c, instr_valid, instr_pc);
        end
      end
      if (c == 10) begin
        total++;
        if ({instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc} !== {1'b1, 8'h10, 8'h11, 16'h1312, 8'h10}) begin
          bad++;
          $display("FAIL rpush_instr got v=%0b op=%h rg=%h opd=%h pc=%h want 1 10 11 1312 10",
                   instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc);
        end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    restart();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      instr_ready = 1'b0;
      #1;
    end
    total++;
    if (mem_addr !== 8'd3) begin
      bad++;
      $display("FAIL rmid_pre_addr got %0d want 3", mem_addr);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({mem_rd, mem_addr, instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc, fetch_pc} !== '0) begin
      bad++;
      $display("FAIL rmid_outputs got rd=%0b addr=%h v=%0b op=%h rg=%h opd=%h pc=%h fpc=%h want all 0",
               mem_rd, mem_addr, instr_valid, instr_opcode, instr_reg, instr_operand, instr_pc, fetch_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++;
      if (instr_valid !== (c == 5)) begin
        bad++;
        $display("FAIL rmid_valid cyc=%0d got %0b want %0b", c, instr_valid, (c == 5));
      end
      if (c == 5) begin
        total++;
        if ({instr_opcode, instr_reg, instr_operand, instr_pc} !== {8'd2, 8'd0, 16'h0010, 8'd0}) begin
          bad++;
          $display("FAIL rmid_instr got op=%h rg=%h opd=%h pc=%h want 02 00 0010 00",
                   instr_opcode, instr_reg, instr_operand, instr_pc);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < RAMSIZE; i++) ram[i] = 8'(i);
    ram[0] = 8'd2;  ram[1] = 8'd0; ram[2] = 8'd16; ram[3] = 8'd0;
    ram[4] = 8'd4;  ram[5] = 8'd0; ram[6] = 8'd1;  ram[7] = 8'd0;

    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_redirect_push();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
